// File: rtl/lifo_stack_if.sv
// lifo_stack_if: bundle of the push/pop strobes, data paths and status
// outputs of lifo_stack.
//   master modport: the control unit side. It drives push, pop, clear_err
//                   and data_in, and observes the data and status outputs.
//   slave modport:  the stack side (lifo_stack).
// WIDTH_DATA and DEPTH must match the lifo_stack instance parameters so
// that data_out/top_data and count have matching widths.
interface lifo_stack_if #(
    parameter int WIDTH_DATA = 32,
    parameter int DEPTH      = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                  push;
    logic                  pop;
    logic                  clear_err;
    logic [WIDTH_DATA-1:0] data_in;
    logic [WIDTH_DATA-1:0] data_out;
    logic                  out_valid;
    logic [WIDTH_DATA-1:0] top_data;
    logic [CNT_W-1:0]      count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, clear_err, data_in,
        input  data_out, out_valid, top_data, count, full, empty,
               overflow, underflow
    );

    modport slave (
        input  push, pop, clear_err, data_in,
        output data_out, out_valid, top_data, count, full, empty,
               overflow, underflow
    );
endinterface

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised circular LIFO used for call/return addresses and
// expression evaluation.
//   clk    : clock, all state updates on the rising edge
//   reset  : synchronous active-high reset, overrides every other input
//   bus    : lifo_stack_if slave modport
//            push/pop/clear_err/data_in : single-cycle strobes and push data
//            data_out/out_valid         : registered popped value, 1-cycle pulse
//            top_data                   : combinational peek, 0 when empty
//            count/full/empty           : occupancy
//            overflow/underflow         : sticky error flags
// Push and pop together replace the top entry (or pass data_in straight
// through when empty). With WRAP_ON_FULL=1 a push while full overwrites the
// oldest entry, which is exactly the slot sp points at.
module lifo_stack #(
    parameter int WIDTH_DATA   = 32,
    parameter int DEPTH        = 16,
    parameter int WRAP_ON_FULL = 0
) (
    input  logic          clk,
    input  logic          reset,
    lifo_stack_if.slave   bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SP_W  = $clog2(DEPTH);
    localparam logic [SP_W-1:0]  SP_LAST  = SP_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [SP_W-1:0]       sp_reg, sp_next;
    logic [SP_W-1:0]       sp_inc, top_idx;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic [WIDTH_DATA-1:0] data_out_reg, data_out_next;
    logic                  out_valid_reg, out_valid_next;
    logic                  overflow_reg, overflow_next;
    logic                  underflow_reg, underflow_next;
    logic                  ovf_evt, unf_evt;
    logic                  wr_en;
    logic [SP_W-1:0]       wr_idx;
    logic                  is_full, is_empty;
    logic [WIDTH_DATA-1:0] mem_q [DEPTH];

    // Explicit modulo-DEPTH wrap so non-power-of-two depths work.
    assign sp_inc  = (sp_reg == SP_LAST) ? '0 : sp_reg + SP_W'(1);
    assign top_idx = (sp_reg == '0) ? SP_LAST : sp_reg - SP_W'(1);

    assign is_full  = (count_reg == CNT_FULL);
    assign is_empty = (count_reg == '0);

    // Storage entries: one register per slot, no reset. Writes are
    // suppressed in the reset cycle so a concurrent push leaves no trace.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH_DATA-1:0] entry_reg;
            always_ff @(posedge clk) begin
                if (!reset && wr_en && (wr_idx == SP_W'(gi))) begin
                    entry_reg <= bus.data_in;
                end
            end
            assign mem_q[gi] = entry_reg;
        end
    endgenerate

    always_comb begin
        sp_next        = sp_reg;
        count_next     = count_reg;
        data_out_next  = data_out_reg;
        out_valid_next = 1'b0;
        wr_en          = 1'b0;
        wr_idx         = sp_reg;
        ovf_evt        = 1'b0;
        unf_evt        = 1'b0;

        case ({bus.push, bus.pop})
            2'b10: begin
                if (!is_full) begin
                    wr_en      = 1'b1;
                    sp_next    = sp_inc;
                    count_next = count_reg + CNT_W'(1);
                end else if (WRAP_ON_FULL != 0) begin
                    // sp points at the oldest entry when full.
                    wr_en   = 1'b1;
                    sp_next = sp_inc;
                end else begin
                    ovf_evt = 1'b1;
                end
            end
            2'b01: begin
                if (!is_empty) begin
                    data_out_next  = mem_q[top_idx];
                    out_valid_next = 1'b1;
                    sp_next        = top_idx;
                    count_next     = count_reg - CNT_W'(1);
                end else begin
                    unf_evt = 1'b1;
                end
            end
            2'b11: begin
                if (!is_empty) begin
                    // Replace top: old top leaves, new value takes its slot.
                    data_out_next  = mem_q[top_idx];
                    out_valid_next = 1'b1;
                    wr_en          = 1'b1;
                    wr_idx         = top_idx;
                end else begin
                    data_out_next  = bus.data_in;
                    out_valid_next = 1'b1;
                end
            end
            default: ;
        endcase

        // A new error event beats a same-cycle clear.
        overflow_next  = ovf_evt | (overflow_reg  & ~bus.clear_err);
        underflow_next = unf_evt | (underflow_reg & ~bus.clear_err);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp_reg        <= '0;
            count_reg     <= '0;
            data_out_reg  <= '0;
            out_valid_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            sp_reg        <= sp_next;
            count_reg     <= count_next;
            data_out_reg  <= data_out_next;
            out_valid_reg <= out_valid_next;
            overflow_reg  <= overflow_next;
            underflow_reg <= underflow_next;
        end
    end

    assign bus.data_out  = data_out_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.top_data  = is_empty ? '0 : mem_q[top_idx];
    assign bus.count     = count_reg;
    assign bus.full      = is_full;
    assign bus.empty     = is_empty;
    assign bus.overflow  = overflow_reg;
    assign bus.underflow = underflow_reg;
endmodule

// File: tb/tb_lifo_stack.sv
module tb_lifo_stack;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    always #5 clk = ~clk;

    // A: DEPTH=4 drop-on-full, B: DEPTH=4 wrap, C: DEPTH=5 wrap.
    lifo_stack_if #(.WIDTH_DATA(8), .DEPTH(4)) if_a ();
    lifo_stack_if #(.WIDTH_DATA(8), .DEPTH(4)) if_b ();
    lifo_stack_if #(.WIDTH_DATA(8), .DEPTH(5)) if_c ();

    lifo_stack #(.WIDTH_DATA(8), .DEPTH(4), .WRAP_ON_FULL(0)) dut_a (
        .clk(clk), .reset(rst_a), .bus(if_a.slave));
    lifo_stack #(.WIDTH_DATA(8), .DEPTH(4), .WRAP_ON_FULL(1)) dut_b (
        .clk(clk), .reset(rst_b), .bus(if_b.slave));
    lifo_stack #(.WIDTH_DATA(8), .DEPTH(5), .WRAP_ON_FULL(1)) dut_c (
        .clk(clk), .reset(rst_c), .bus(if_c.slave));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%0h expected=%0h", vectors, tag, obs, exp);
    endtask

    // Each cyc_* task applies one cycle of strobes, then samples 1 time unit
    // after the edge with the strobes returned to idle.
    task automatic cyc_a(input logic p, input logic po, input logic c, input logic [7:0] d);
        if_a.push = p; if_a.pop = po; if_a.clear_err = c; if_a.data_in = d;
        @(posedge clk); #1;
        if_a.push = 0; if_a.pop = 0; if_a.clear_err = 0; if_a.data_in = 8'h00;
    endtask
    task automatic cyc_b(input logic p, input logic po, input logic c, input logic [7:0] d);
        if_b.push = p; if_b.pop = po; if_b.clear_err = c; if_b.data_in = d;
        @(posedge clk); #1;
        if_b.push = 0; if_b.pop = 0; if_b.clear_err = 0; if_b.data_in = 8'h00;
    endtask
    task automatic cyc_c(input logic p, input logic po, input logic c, input logic [7:0] d);
        if_c.push = p; if_c.pop = po; if_c.clear_err = c; if_c.data_in = d;
        @(posedge clk); #1;
        if_c.push = 0; if_c.pop = 0; if_c.clear_err = 0; if_c.data_in = 8'h00;
    endtask

    initial begin
        logic [7:0] exp_pop_a [4];
        logic [7:0] exp_pop_b [4];
        logic [7:0] v;
        exp_pop_a = '{8'h44, 8'h33, 8'h22, 8'h11};
        exp_pop_b = '{8'h55, 8'h44, 8'h33, 8'h22};

        if_a.push = 0; if_a.pop = 0; if_a.clear_err = 0; if_a.data_in = 0;
        if_b.push = 0; if_b.pop = 0; if_b.clear_err = 0; if_b.data_in = 0;
        if_c.push = 0; if_c.pop = 0; if_c.clear_err = 0; if_c.data_in = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_a = 0; rst_b = 0; rst_c = 0;

        // ---- Reset state and empty pop (A) ----
        check("a_rst_count", 32'(if_a.count), 0);
        check("a_rst_empty", 32'(if_a.empty), 1);
        check("a_rst_full", 32'(if_a.full), 0);
        check("a_rst_dout", 32'(if_a.data_out), 0);
        check("a_rst_top", 32'(if_a.top_data), 0);
        cyc_a(0, 1, 0, 8'h00);
        check("a_epop_valid", 32'(if_a.out_valid), 0);
        check("a_epop_unf", 32'(if_a.underflow), 1);
        check("a_epop_dout", 32'(if_a.data_out), 0);
        cyc_a(0, 0, 1, 8'h00);
        check("a_clr_unf", 32'(if_a.underflow), 0);

        // ---- Fill and drain, drop on full ----
        cyc_a(1, 0, 0, 8'h11);
        check("a_push1_top", 32'(if_a.top_data), 32'h11);
        check("a_push1_count", 32'(if_a.count), 1);
        cyc_a(1, 0, 0, 8'h22);
        cyc_a(1, 0, 0, 8'h33);
        cyc_a(1, 0, 0, 8'h44);
        check("a_fill_full", 32'(if_a.full), 1);
        check("a_fill_top", 32'(if_a.top_data), 32'h44);
        check("a_fill_count", 32'(if_a.count), 4);
        cyc_a(1, 0, 0, 8'h55);
        check("a_ovf_flag", 32'(if_a.overflow), 1);
        check("a_ovf_count", 32'(if_a.count), 4);
        check("a_ovf_top", 32'(if_a.top_data), 32'h44);
        for (int i = 0; i < 4; i++) begin
            cyc_a(0, 1, 0, 8'h00);
            check($sformatf("a_drain%0d_dout", i), 32'(if_a.data_out), 32'(exp_pop_a[i]));
            check($sformatf("a_drain%0d_valid", i), 32'(if_a.out_valid), 1);
        end
        check("a_drain_empty", 32'(if_a.empty), 1);
        check("a_drain_ovf_sticky", 32'(if_a.overflow), 1);
        cyc_a(0, 0, 0, 8'h00);
        check("a_idle_valid", 32'(if_a.out_valid), 0);
        check("a_idle_dout_hold", 32'(if_a.data_out), 32'h11);

        // ---- Simultaneous push+pop ----
        cyc_a(1, 0, 0, 8'h11);
        cyc_a(1, 0, 0, 8'h22);
        cyc_a(1, 1, 0, 8'hAA);
        check("a_rep_dout", 32'(if_a.data_out), 32'h22);
        check("a_rep_valid", 32'(if_a.out_valid), 1);
        check("a_rep_count", 32'(if_a.count), 2);
        check("a_rep_top", 32'(if_a.top_data), 32'hAA);
        cyc_a(0, 1, 0, 8'h00);
        check("a_rep_pop1", 32'(if_a.data_out), 32'hAA);
        cyc_a(0, 1, 0, 8'h00);
        check("a_rep_pop2", 32'(if_a.data_out), 32'h11);
        cyc_a(1, 1, 0, 8'hBB);
        check("a_pass_dout", 32'(if_a.data_out), 32'hBB);
        check("a_pass_valid", 32'(if_a.out_valid), 1);
        check("a_pass_count", 32'(if_a.count), 0);
        check("a_pass_unf", 32'(if_a.underflow), 0);
        check("a_pass_top", 32'(if_a.top_data), 0);

        // ---- Reset mid-stream with push asserted ----
        cyc_a(1, 0, 0, 8'h01);
        cyc_a(1, 0, 0, 8'h02);
        cyc_a(1, 0, 0, 8'h03);
        check("a_pre_rst_count", 32'(if_a.count), 3);
        rst_a = 1;
        cyc_a(1, 1, 0, 8'h99);
        rst_a = 0;
        check("a_mid_rst_count", 32'(if_a.count), 0);
        check("a_mid_rst_valid", 32'(if_a.out_valid), 0);
        check("a_mid_rst_empty", 32'(if_a.empty), 1);
        check("a_mid_rst_ovf", 32'(if_a.overflow), 0);
        check("a_mid_rst_top", 32'(if_a.top_data), 0);

        // ---- Error set beats clear ----
        cyc_a(0, 1, 1, 8'h00);
        check("a_setclr_unf", 32'(if_a.underflow), 1);
        cyc_a(0, 0, 1, 8'h00);
        check("a_clr2_unf", 32'(if_a.underflow), 0);

        // ---- Wrap mode, DEPTH=4 (B) ----
        cyc_b(1, 0, 0, 8'h11);
        cyc_b(1, 0, 0, 8'h22);
        cyc_b(1, 0, 0, 8'h33);
        cyc_b(1, 0, 0, 8'h44);
        cyc_b(1, 0, 0, 8'h55);
        check("b_wrap_count", 32'(if_b.count), 4);
        check("b_wrap_ovf", 32'(if_b.overflow), 0);
        check("b_wrap_top", 32'(if_b.top_data), 32'h55);
        for (int i = 0; i < 4; i++) begin
            cyc_b(0, 1, 0, 8'h00);
            check($sformatf("b_pop%0d_dout", i), 32'(if_b.data_out), 32'(exp_pop_b[i]));
        end
        check("b_end_empty", 32'(if_b.empty), 1);

        // ---- Non-power-of-two DEPTH=5, wrap (C) ----
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 7; i++) begin
                v = 8'((r + 1) * 16 + i);
                cyc_c(1, 0, 0, v);
                check($sformatf("c_r%0d_push%0d_count", r, i), 32'(if_c.count),
                      32'((i < 5) ? i + 1 : 5));
                check($sformatf("c_r%0d_push%0d_top", r, i), 32'(if_c.top_data), 32'(v));
            end
            check($sformatf("c_r%0d_full", r), 32'(if_c.full), 1);
            for (int i = 0; i < 5; i++) begin
                cyc_c(0, 1, 0, 8'h00);
                check($sformatf("c_r%0d_pop%0d", r, i), 32'(if_c.data_out),
                      32'((r + 1) * 16 + 6 - i));
            end
            check($sformatf("c_r%0d_empty", r), 32'(if_c.empty), 1);
            cyc_c(0, 1, 0, 8'h00);
            check($sformatf("c_r%0d_xpop_valid", r), 32'(if_c.out_valid), 0);
            check($sformatf("c_r%0d_xpop_unf", r), 32'(if_c.underflow), 1);
            check($sformatf("c_r%0d_xpop_hold", r), 32'(if_c.data_out), 32'((r + 1) * 16 + 2));
            cyc_c(0, 0, 1, 8'h00);
            check($sformatf("c_r%0d_clr", r), 32'(if_c.underflow), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
